// File: rtl/cle_label_packer_pkg.sv
// Shared constants, FSM state type and label-map to packed-image address helpers.
package cle_pkg;

  localparam int IMG_DIM    = 32;
  localparam int PIX_ADDR_W = 2 * $clog2(IMG_DIM);
  localparam int PK_BYTES   = 128;
  localparam int PK_ADDR_W  = $clog2(PK_BYTES);

  localparam logic [PIX_ADDR_W-1:0] PIX_LAST = '1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  // Packed byte holding pixel {row,col}: {row, col[4:3]}
  function automatic logic [PK_ADDR_W-1:0] pk_byte_idx(input logic [PIX_ADDR_W-1:0] pix);
    return pix[PIX_ADDR_W-1:3];
  endfunction

  // Bit within that byte; the lowest column lands in the MSB
  function automatic logic [2:0] pk_bit_idx(input logic [PIX_ADDR_W-1:0] pix);
    return 3'd7 - pix[2:0];
  endfunction

endpackage

// File: rtl/cle_bit_packer.sv
// MSB-first bit accumulator: presents a full byte combinationally alongside its 8th bit.
module cle_bit_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic       byte_valid,
  output logic [7:0] pk_byte
);

  logic [6:0] sr;
  logic [2:0] cnt;

  assign byte_valid = bit_en && (cnt == 3'd7);
  assign pk_byte    = {sr, bit_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bit_en) begin
      sr  <= {sr[5:0], bit_in};
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/cle_label_packer.sv
// Reads the 32x32 label map back and writes it out as the 128-byte packed binary image.
// Optional CLE_PIXCNT_EN builds a foreground pixel counter on pix_cnt (tied to 0 otherwise).
module cle_label_packer
  import cle_pkg::*;
#(
  parameter int LABEL_W     = 8,
  parameter bit DONE_STICKY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [PIX_ADDR_W-1:0] sram_a,
  input  logic [LABEL_W-1:0]    sram_q,
  output logic                  sram_wen,
  output logic [PK_ADDR_W-1:0]  pk_a,
  output logic [7:0]            pk_d,
  output logic                  pk_wen,
  output logic [PIX_ADDR_W:0]   pix_cnt
);

  state_e                state, state_nxt;
  logic                  accept;
  logic                  rd_vld;  // sram_q carries the pixel at cap_a this cycle
  logic [PIX_ADDR_W-1:0] cap_a;
  logic                  fg;
  logic                  byte_valid;
  logic [7:0]            pk_byte;

  assign accept   = (state == IDLE) && start;
  assign busy     = (state == READ) || (state == DRAIN);
  assign sram_wen = 1'b1;
  assign fg       = |sram_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (sram_a == PIX_LAST) state_nxt = DRAIN;
      // first DRAIN cycle still captures the last pixel; second carries the last write
      DRAIN:   if (!rd_vld) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sram_a <= '0;
      rd_vld <= 1'b0;
      cap_a  <= '0;
      pk_a   <= '0;
      pk_d   <= '0;
      pk_wen <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sram_a <= (state == READ && sram_a != PIX_LAST) ? sram_a + 1'b1 : '0;
      rd_vld <= (state == READ);
      cap_a  <= sram_a;
      pk_wen <= !byte_valid;
      if (byte_valid) begin
        pk_d <= pk_byte;
        pk_a <= pk_byte_idx(cap_a);
      end
      if (accept)
        done <= 1'b0;
      else if (state_nxt == DONE)
        done <= 1'b1;
      else if (!DONE_STICKY)
        done <= 1'b0;
    end
  end

  cle_bit_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .clr        (accept),
    .bit_en     (rd_vld),
    .bit_in     (fg),
    .byte_valid (byte_valid),
    .pk_byte    (pk_byte)
  );

`ifdef CLE_PIXCNT_EN
  logic [PIX_ADDR_W:0] pix_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pix_q <= '0;
    else if (accept)
      pix_q <= '0;
    else if (rd_vld && fg)
      pix_q <= pix_q + 1'b1;
  end

  assign pix_cnt = pix_q;
`else
  assign pix_cnt = '0;
`endif

endmodule

// File: tb/tb_cle_label_packer.sv
// Directed bench: SRAM and packed-memory models, pass timing, restart, mid-pass reset, round trip.
module tb_cle_label_packer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, sram_wen, pk_wen;
  logic [9:0]  sram_a;
  logic [7:0]  sram_q;
  logic [6:0]  pk_a;
  logic [7:0]  pk_d;
  logic [10:0] pix_cnt;

  cle_label_packer #(.LABEL_W(8), .DONE_STICKY(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .sram_a(sram_a), .sram_q(sram_q), .sram_wen(sram_wen),
    .pk_a(pk_a), .pk_d(pk_d), .pk_wen(pk_wen), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  logic [7:0] pkmem [128];
  logic [7:0] exp_pk [128];
  logic [7:0] rom [128];

  always @(posedge clk) sram_q <= mem[sram_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   wcnt = 0, b2b = 0, bad_wen = 0, dn_cnt = 0, done_cyc = 0;
  int   wr_cyc_log [2048];
  int   wr_a_log   [2048];
  logic prev_wen = 1'b1, prev_done = 1'b0;

  always @(posedge clk) begin
    if (sram_wen !== 1'b1) bad_wen++;
    if (pk_wen === 1'b0) begin
      pkmem[pk_a] = pk_d;
      if (wcnt < 2048) begin
        wr_cyc_log[wcnt] = cyc;
        wr_a_log[wcnt]   = int'(pk_a);
      end
      wcnt++;
      if (prev_wen === 1'b0) b2b++;
    end
    if (done === 1'b1 && prev_done !== 1'b1) begin
      dn_cnt++;
      done_cyc = cyc;
    end
    prev_wen  = pk_wen;
    prev_done = done;
  end

  int n_cmp = 0, n_err = 0;
  int s_cyc, w0, d0, w1, pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pexp(input int n);
`ifdef CLE_PIXCNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Leaves the bench at the negedge inside cycle S+1
  task automatic start_pass();
    @(negedge clk);
    w0 = wcnt;
    d0 = dn_cnt;
    start = 1'b1;
    @(posedge clk);
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1200 && dn_cnt == d0; i++) @(negedge clk);
    chk("done_seen", dn_cnt - d0, 1);
  endtask

  task automatic check_pass(input string tag);
    chk({tag, "_writes"},    wcnt - w0, 128);
    chk({tag, "_first_cyc"}, wr_cyc_log[w0] - s_cyc, 10);
    chk({tag, "_first_a"},   wr_a_log[w0], 0);
    chk({tag, "_last_cyc"},  wr_cyc_log[w0 + 127] - s_cyc, 1026);
    chk({tag, "_last_a"},    wr_a_log[w0 + 127], 127);
    chk({tag, "_done_cyc"},  done_cyc - s_cyc, 1027);
    chk({tag, "_busy_end"},  busy, 0);
    chk({tag, "_done_end"},  done, 1);
  endtask

  task automatic check_bytes(input string tag);
    int nbad = 0;
    for (int k = 0; k < 128; k++) if (pkmem[k] !== exp_pk[k]) nbad++;
    chk({tag, "_bytes_bad"}, nbad, 0);
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sram_a", sram_a, 0);
    chk("rst_sram_wen", sram_wen, 1);
    chk("rst_pk_a", pk_a, 0);
    chk("rst_pk_d", pk_d, 0);
    chk("rst_pk_wen", pk_wen, 1);
    chk("rst_pix", pix_cnt, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // all-zero map
    for (int k = 0; k < 128; k++) exp_pk[k] = 8'h00;
    start_pass();
    chk("zero_busy_s1", busy, 1);
    chk("zero_a_s1", sram_a, 0);
    @(negedge clk);
    chk("zero_a_s2", sram_a, 1);
    wait_done();
    check_pass("zero");
    check_bytes("zero");
    chk("zero_pix", pix_cnt, pexp(0));
    repeat (5) @(negedge clk);
    chk("sticky_done", done, 1);

    // two corner pixels
    mem[0] = 8'h05;
    mem[1023] = 8'hFB;
    exp_pk[0] = 8'h80;
    exp_pk[127] = 8'h01;
    start_pass();
    chk("corner_done_clr", done, 0);
    wait_done();
    check_pass("corner");
    chk("corner_b0", pkmem[0], 8'h80);
    chk("corner_b127", pkmem[127], 8'h01);
    check_bytes("corner");
    chk("corner_pix", pix_cnt, pexp(2));

    // start pulsed again mid-pass must be ignored
    start_pass();
    repeat (499) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_pass("restart");
    check_bytes("restart");

    // reset at S+300 aborts the pass
    start_pass();
    repeat (299) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_pk_wen", pk_wen, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sram_a", sram_a, 0);
    w1 = wcnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_no_writes", wcnt - w1, 0);

    // round trip: expand a ROM image into nonzero labels, pack it back
    pc = 0;
    for (int k = 0; k < 128; k++) begin
      rom[k] = 8'(k * 37 + 5);
      exp_pk[k] = rom[k];
      pc += $countones(rom[k]);
    end
    for (int i = 0; i < 1024; i++) begin
      logic [7:0] rb;
      rb = rom[i / 8];
      mem[i] = rb[7 - (i % 8)] ? 8'((i % 250) + 1) : 8'h00;
    end
    start_pass();
    wait_done();
    check_pass("rtrip");
    check_bytes("rtrip");
    chk("rtrip_pix", pix_cnt, pexp(pc));

    // every label 0xFF
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    for (int k = 0; k < 128; k++) exp_pk[k] = 8'hFF;
    start_pass();
    wait_done();
    check_pass("full");
    check_bytes("full");
    chk("full_pix", pix_cnt, pexp(1024));

    chk("no_back_to_back", b2b, 0);
    chk("sram_wen_high", bad_wen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
